display_arbiter: RTL
====================

Name: display_arbiter

Overview:
- Round-robin arbiter that shares one two-digit seven-segment driver between NUM_REQ requesters, e.g. frequency result, status code and error code.
- Each requester presents a two-digit BCD value and a request. The arbiter grants one requester and issues a single-cycle load with that requester's digits.
- The granted value stays on the display for a guaranteed dwell time before the display is handed to the next requester.
- Sits between the requesting blocks and the seven-segment driver's load, ten_count and unit_count inputs.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- DWELL_CYCLES, 1024, minimum clocks a granted value is displayed, counting the load cycle; minimum legal value 2.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- req  input  NUM_REQ  level request per requester.
- bcd_in  input  8*NUM_REQ  requester i digits at bits [8i+7:8i]; ten digit in the upper nibble, unit digit in the lower nibble.
- grant  output  NUM_REQ  one-hot current display owner; all zero when no owner.
- ack  output  NUM_REQ  one-cycle pulse to requester i when its value is loaded.
- load  output  1  one-cycle load strobe to the driver.
- ten_count  output  4  captured ten digit.
- unit_count  output  4  captured unit digit.
- busy  output  1  high while in LOAD or HOLD.

Behaviour:
- All outputs are registered. Reset values:
  - grant=0, ack=0, load=0, ten_count=0, unit_count=0, busy=0.
  - State=IDLE, dwell counter=0.
  - Round-robin pointer last_owner=NUM_REQ-1, so req[0] has first priority after reset.
- States: IDLE, LOAD, HOLD.
- Arbitration (combinational):
  - Search req starting at index last_owner+1, wrapping modulo NUM_REQ.
  - The first set bit wins.
  - last_owner updates to the winner on the edge entering LOAD.
- IDLE:
  - If any req is high, on the next edge go to LOAD.
  - On that edge, set grant to the winner (one-hot), capture its bcd_in into ten_count/unit_count, set load=1 and ack[winner]=1.
  - Latency: req high at edge N produces load, ack and grant high in cycle N+1.
- LOAD (exactly 1 cycle):
  - load and ack are high.
  - Dwell counter loads DWELL_CYCLES-2.
  - Next state is HOLD.
- HOLD:
  - load=0, ack=0; grant and digits are held.
  - Counter decrements each cycle.
  - When the counter is 0 and any req is high: arbitrate and go to LOAD. The current owner is eligible only if no other request is pending; this is refresh behaviour, and the owner's new bcd_in is captured.
  - When the counter is 0 and no req is high: go to IDLE. grant clears to 0, busy=0, ten_count/unit_count keep their last value, and no load is issued.
- Load spacing: consecutive load pulses are exactly DWELL_CYCLES clocks apart while requests are continuously pending.
- Owner deasserting req during HOLD does not shorten the dwell.
- Changes on bcd_in outside the capture edge are ignored.
- Digits above 9 are passed through unchanged; the driver blanks them.
- Simultaneous requests are resolved purely by the round-robin order.
- Reset asserted mid-LOAD or mid-HOLD:
  - All outputs clear asynchronously and the load pulse is truncated.
  - After release, arbitration restarts from req[0] priority.
- busy = (state != IDLE).

Optional Feature:
- Macro: DISPLAY_ARB_PREEMPT_EN.
- Defined:
  - req[0] is the urgent channel.
  - If req[0] is high in HOLD while the owner is not 0, the dwell is abandoned. On the next edge the block goes to LOAD with grant[0], ignoring the round-robin pointer.
  - In IDLE or at dwell expiry, req[0] also beats all other requesters.
  - Requester 0's own dwell is never preempted.
- Not defined:
  - req[0] is an ordinary round-robin requester.
  - HOLD always runs the full dwell.

Test Plan:
- Reset, then req=4'b0001 with bcd_in[7:0]=8'h42 -> one cycle later load=1, ack=4'b0001, grant=4'b0001, ten_count=4, unit_count=2. Next load only after DWELL_CYCLES, and only if req is still high (refresh).
- DWELL_CYCLES=8, req=4'b1111 held -> grant sequence 0001,0010,0100,1000,0001 with load pulses exactly 8 clocks apart; each ack pulse coincides with its load.
- Single request req=4'b0100 pulsed for 1 cycle -> LOAD then HOLD for the full dwell, then IDLE with grant=0, busy=0 and digits retained.
- Reset driven low during HOLD -> grant, load, ack, busy and digits go to 0 without a clock edge. After release, req=4'b1001 -> grant=4'b0001 first.
- DISPLAY_ARB_PREEMPT_EN, DWELL_CYCLES=16, owner 2 in HOLD, req[0] raised 3 cycles into the dwell -> next edge gives load=1 and grant=4'b0001. Without the macro, req[0] waits for the full dwell and the round-robin turn.
- bcd_in=8'hAB for the granted requester -> ten_count=10 and unit_count=11 are passed through unmodified.

Source files
------------

// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing one two-digit seven-segment driver between NUM_REQ requesters.
// Optional urgent channel on req[0] when DISPLAY_ARB_PREEMPT_EN is defined.
module display_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] bcd_in,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 load,
  output logic [3:0]           ten_count,
  output logic [3:0]           unit_count,
  output logic                 busy,
  output logic [1:0]           fsm_state
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(DWELL_CYCLES);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, HOLD = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      last_owner_q, last_owner_d;
  logic [IW-1:0]      win, idx;
  logic               found;
  logic [NUM_REQ-1:0] win_oh;
  logic [7:0]         win_bcd;
  logic               take;
  logic [NUM_REQ-1:0] grant_d, ack_d;
  logic               load_d, busy_d;
  logic [3:0]         ten_d, unit_d;

  // Search starts just after the last owner, so the owner itself is checked last.
  always_comb begin
    win   = last_owner_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IW'((int'(last_owner_q) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
`ifdef DISPLAY_ARB_PREEMPT_EN
    if (req[0]) begin
      found = 1'b1;
      win   = '0;
    end
`endif
  end

  assign win_oh  = NUM_REQ'(1) << win;
  assign win_bcd = bcd_in[{win, 3'b000} +: 8];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    grant_d      = grant;
    ack_d        = '0;
    load_d       = 1'b0;
    ten_d        = ten_count;
    unit_d       = unit_count;
    take         = 1'b0;
    case (state_q)
      IDLE: take = found;
      LOAD: begin
        state_d = HOLD;
        cnt_d   = CW'(DWELL_CYCLES - 2);
      end
      HOLD: begin
`ifdef DISPLAY_ARB_PREEMPT_EN
        if (req[0] && !grant[0]) begin
          take = 1'b1;
        end else
`endif
        if (cnt_q == '0) begin
          if (found) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d      = LOAD;
      last_owner_d = win;
      grant_d      = win_oh;
      ack_d        = win_oh;
      load_d       = 1'b1;
      ten_d        = win_bcd[7:4];
      unit_d       = win_bcd[3:0];
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_owner_q <= IW'(NUM_REQ - 1);
      grant        <= '0;
      ack          <= '0;
      load         <= 1'b0;
      ten_count    <= '0;
      unit_count   <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      grant        <= grant_d;
      ack          <= ack_d;
      load         <= load_d;
      ten_count    <= ten_d;
      unit_count   <= unit_d;
      busy         <= busy_d;
    end
  end

  assign fsm_state = state_q;

endmodule
